// File: rtl/half_adder_pkg.sv
// Shared types and constants for the half_adder slice: per-lane result type
// and the width/limit of the optional statistics counters.
package half_adder_pkg;

   localparam int STAT_W = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   typedef struct packed {
      logic sum;
      logic carry;
   } ha_result_t;

   // Saturating increment used by the statistics counters
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
      logic [STAT_W-1:0] nxt;
      nxt = val;
      if (val != STAT_MAX) begin
         nxt = val + 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ha_cell.sv
// Single-bit combinational half adder; replicated once per lane by half_adder.
module ha_cell
   import half_adder_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output ha_result_t res
);

   assign res.sum   = a ^ b;
   assign res.carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Lane-parallel half adder with valid qualification and optional output register.
// Build option: define HALF_ADDER_STATS_EN to add saturating op/carry counters.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int REG_OUT = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   output logic [WIDTH-1:0]  sum,
   output logic [WIDTH-1:0]  carry,
   output logic              out_valid
`ifdef HALF_ADDER_STATS_EN
   ,
   output logic [STAT_W-1:0] op_count,
   output logic [STAT_W-1:0] carry_count
`endif
);

   ha_result_t        lane_res [WIDTH];
   logic [WIDTH-1:0]  sum_c;
   logic [WIDTH-1:0]  carry_c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      ha_cell u_cell (
         .a   (A[i]),
         .b   (B[i]),
         .res (lane_res[i])
      );
      assign sum_c[i]   = lane_res[i].sum;
      assign carry_c[i] = lane_res[i].carry;
   end

   if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] sum_q;
      logic [WIDTH-1:0] carry_q;
      logic             valid_q;

      // Results only load on accept so idle inputs cannot disturb held outputs
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= in_valid;
            if (in_valid) begin
               sum_q   <= sum_c;
               carry_q <= carry_c;
            end
         end
      end

      assign sum       = sum_q;
      assign carry     = carry_q;
      assign out_valid = valid_q;
   end else begin : g_bypass
      assign sum       = sum_c;
      assign carry     = carry_c;
      assign out_valid = in_valid;
   end

`ifdef HALF_ADDER_STATS_EN
   logic [STAT_W-1:0] op_cnt_q;
   logic [STAT_W-1:0] carry_cnt_q;

   // Counted at the accepting edge from the combinational result, so REG_OUT has no effect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_cnt_q    <= '0;
         carry_cnt_q <= '0;
      end else if (in_valid) begin
         op_cnt_q <= sat_inc(op_cnt_q);
         if (|carry_c) begin
            carry_cnt_q <= sat_inc(carry_cnt_q);
         end
      end
   end

   assign op_count    = op_cnt_q;
   assign carry_count = carry_cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: registered 4-lane instance plus a 1-lane bypass instance.
module tb_half_adder;

   logic       clk;
   logic       rst;
   logic       v4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic [3:0] s4;
   logic [3:0] c4;
   logic       ov4;

   logic       v1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic [0:0] s1;
   logic [0:0] c1;
   logic       ov1;

`ifdef HALF_ADDER_STATS_EN
   logic [15:0] opc4;
   logic [15:0] crc4;
   logic [15:0] opc1;
   logic [15:0] crc1;
   int          op_model;
   int          cr_model;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q [$];
   logic [3:0] hold_s;
   logic [3:0] hold_c;

   half_adder #(.WIDTH(4), .REG_OUT(1)) dut_reg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v4),
      .A         (a4),
      .B         (b4),
      .sum       (s4),
      .carry     (c4),
      .out_valid (ov4)
`ifdef HALF_ADDER_STATS_EN
      ,
      .op_count    (opc4),
      .carry_count (crc4)
`endif
   );

   half_adder #(.WIDTH(1), .REG_OUT(0)) dut_comb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v1),
      .A         (a1),
      .B         (b1),
      .sum       (s1),
      .carry     (c1),
      .out_valid (ov1)
`ifdef HALF_ADDER_STATS_EN
      ,
      .op_count    (opc1),
      .carry_count (crc1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: each lane adds two one-bit numbers; bit 0 of the total is sum, bit 1 carry
   function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] s;
      logic [3:0] c;
      int         tot;
      for (int i = 0; i < 4; i++) begin
         tot  = int'(a[i]) + int'(b[i]);
         s[i] = (tot % 2) == 1;
         c[i] = (tot / 2) == 1;
      end
      return {s, c};
   endfunction

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] e;
      @(negedge clk);
      v4 = v;
      a4 = a;
      b4 = b;
      if (v && !rst) begin
         e = model(a, b);
         exp_q.push_back(e);
`ifdef HALF_ADDER_STATS_EN
         op_model++;
         if (e[3:0] != 4'd0) cr_model++;
`endif
      end
   endtask

   // Monitor: registered instance presents the result one edge after acceptance
   initial begin
      logic       ev;
      logic [7:0] e;
      hold_s = '0;
      hold_c = '0;
      forever begin
         @(posedge clk);
         ev = v4 && !rst;
         #1;
         if (rst) begin
            exp_q.delete();
            hold_s = '0;
            hold_c = '0;
            ev     = 1'b0;
         end
         chk("out_valid", 32'(ov4), 32'(ev));
         if (ev) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("sum", 32'(s4), 32'(e[7:4]));
               chk("carry", 32'(c4), 32'(e[3:0]));
               hold_s = e[7:4];
               hold_c = e[3:0];
            end
         end else begin
            chk("sum_hold", 32'(s4), 32'(hold_s));
            chk("carry_hold", 32'(c4), 32'(hold_c));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int tot;
      rst = 1'b1;
      v4  = 1'b0;
      a4  = '0;
      b4  = '0;
      v1  = 1'b0;
      a1  = '0;
      b1  = '0;
`ifdef HALF_ADDER_STATS_EN
      op_model = 0;
      cr_model = 0;
`endif
      #12;
      chk("reset_sum", 32'(s4), 32'd0);
      chk("reset_carry", 32'(c4), 32'd0);
      chk("reset_valid", 32'(ov4), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Lane-0 truth table, back-to-back
      drive(1'b1, 4'b0000, 4'b0000);
      drive(1'b1, 4'b0000, 4'b0001);
      drive(1'b1, 4'b0001, 4'b0000);
      drive(1'b1, 4'b0001, 4'b0001);
      drive(1'b1, 4'b1100, 4'b1010);

      // Hold after carry result while inputs wander
      drive(1'b1, 4'b1111, 4'b1111);
      for (int i = 0; i < 5; i++) drive(1'b0, 4'($urandom), 4'($urandom));

      for (int i = 0; i < 200; i++) begin
         drive(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
      end

      // Async reset mid-cycle with carry set and a result in flight
      drive(1'b1, 4'b1111, 4'b1111);
      drive(1'b1, 4'($urandom), 4'($urandom));
      #2;
      chk("pre_reset_carry", 32'(c4), 32'hF);
      rst = 1'b1;
`ifdef HALF_ADDER_STATS_EN
      op_model = 0;
      cr_model = 0;
`endif
      #1;
      chk("async_reset_sum", 32'(s4), 32'd0);
      chk("async_reset_carry", 32'(c4), 32'd0);
      chk("async_reset_valid", 32'(ov4), 32'd0);
      @(negedge clk);
      v4  = 1'b0;
      rst = 1'b0;
      drive(1'b1, 4'b0110, 4'b0011);
      drive(1'b0, 4'b1111, 4'b1111);

      // Bypass instance: zero latency, valid follows input
      for (int i = 0; i < 16; i++) begin
         v1 = 1'($urandom);
         a1 = 1'($urandom);
         b1 = 1'($urandom);
         if (i == 0) begin
            a1 = 1'b1;
            b1 = 1'b1;
         end
         #1;
         tot = int'(a1) + int'(b1);
         chk("comb_sum", 32'(s1), 32'(tot % 2));
         chk("comb_carry", 32'(c1), 32'(tot / 2));
         chk("comb_valid", 32'(ov1), 32'(v1));
      end

`ifdef HALF_ADDER_STATS_EN
      @(posedge clk);
      #1;
      chk("op_count", 32'(opc4), 32'(op_model));
      chk("carry_count", 32'(crc4), 32'(cr_model));
      for (int i = 0; i < 70000; i++) drive(1'b1, 4'b0001, 4'b0001);
      drive(1'b0, 4'b0000, 4'b0000);
      #1;
      chk("op_count_sat", 32'(opc4), 32'hFFFF);
      chk("carry_count_sat", 32'(crc4), 32'hFFFF);
      #2;
      rst = 1'b1;
      #1;
      chk("op_count_rst", 32'(opc4), 32'd0);
      chk("carry_count_rst", 32'(crc4), 32'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
